// File: rtl/sensor_input_conditioner_if.sv
// Bundle of raw sensor/button inputs and conditioned outputs.
// slave: conditioner side (takes raw, drives filtered); master: source/consumer side.
interface sensor_input_conditioner_if;
   logic high_raw;
   logic middle_raw;
   logic low_raw;
   logic umidadeDoSolo_raw;
   logic umidadeDoAr_raw;
   logic temperatura_raw;
   logic seletor_btn_n;
   logic high;
   logic middle;
   logic low;
   logic umidadeDoSolo;
   logic umidadeDoAr;
   logic temperatura;
   logic seletor;
   logic seletor_pulse;
   logic ready;

   modport slave (
      input  high_raw, middle_raw, low_raw,
      input  umidadeDoSolo_raw, umidadeDoAr_raw, temperatura_raw,
      input  seletor_btn_n,
      output high, middle, low,
      output umidadeDoSolo, umidadeDoAr, temperatura,
      output seletor, seletor_pulse, ready
   );

   modport master (
      output high_raw, middle_raw, low_raw,
      output umidadeDoSolo_raw, umidadeDoAr_raw, temperatura_raw,
      output seletor_btn_n,
      input  high, middle, low,
      input  umidadeDoSolo, umidadeDoAr, temperatura,
      input  seletor, seletor_pulse, ready
   );
endinterface

// File: rtl/sensor_input_conditioner.sv
// Synchronises and debounces tank switches, field sensors and the
// active-low page button; toggles the page select and flags startup ready.
// Ports: clk, reset (async, active-high), bus (slave: raw in, filtered out).
module sensor_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input logic clk,
   input logic reset,
   sensor_input_conditioner_if.slave bus
);
   localparam int NCH = 7;
   localparam int BTN = 6;
   // Button channel idles released (1); all others idle at 0.
   localparam logic [NCH-1:0] RST_VAL = 7'b1000000;
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   // ready rises on the edge where the startup count reaches D+2.
   localparam logic [CNT_W-1:0] RDY_LAST = CNT_W'(DEBOUNCE_CYCLES + 1);

   logic [NCH-1:0] raw;
   logic [NCH-1:0] sync1;
   logic [NCH-1:0] sync2;
   logic [NCH-1:0] filt;
   logic [CNT_W-1:0] cnt [NCH];
   logic btn_prev;
   logic press;
   logic seletor_q;
   logic pulse_q;
   logic ready_q;
   logic [CNT_W-1:0] start_cnt;

   assign raw = {bus.seletor_btn_n,
                 bus.temperatura_raw,
                 bus.umidadeDoAr_raw,
                 bus.umidadeDoSolo_raw,
                 bus.low_raw,
                 bus.middle_raw,
                 bus.high_raw};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= RST_VAL;
         sync2 <= RST_VAL;
         filt  <= RST_VAL;
         for (int i = 0; i < NCH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < NCH; i++) begin
            if (sync2[i] == filt[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DB_LAST) begin
               filt[i] <= sync2[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Press = filtered button falling edge, seen one cycle later.
   assign press = btn_prev & ~filt[BTN];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_prev  <= 1'b1;
         pulse_q   <= 1'b0;
         seletor_q <= 1'b0;
      end else begin
         btn_prev <= filt[BTN];
         pulse_q  <= press;
         if (press) begin
            seletor_q <= ~seletor_q;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_cnt <= '0;
         ready_q   <= 1'b0;
      end else if (!ready_q) begin
         start_cnt <= start_cnt + CNT_W'(1);
         if (start_cnt == RDY_LAST) begin
            ready_q <= 1'b1;
         end
      end
   end

   assign bus.high          = filt[0];
   assign bus.middle        = filt[1];
   assign bus.low           = filt[2];
   assign bus.umidadeDoSolo = filt[3];
   assign bus.umidadeDoAr   = filt[4];
   assign bus.temperatura   = filt[5];
   assign bus.seletor       = seletor_q;
   assign bus.seletor_pulse = pulse_q;
   assign bus.ready         = ready_q;
endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Directed bench for sensor_input_conditioner with DEBOUNCE_CYCLES=4.
// Raw vector: {btn_n,temp,ar,solo,low,middle,high}; out: {ready,pulse,sel,temp,ar,solo,low,middle,high}.
module tb_sensor_input_conditioner;
   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   sensor_input_conditioner_if bus ();

   sensor_input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W(19)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         n;
      logic [6:0] raw;
      logic [8:0] exp;
   } seg_t;

   seg_t tbl [10];

   function automatic logic [8:0] outs();
      return {bus.ready, bus.seletor_pulse, bus.seletor,
              bus.temperatura, bus.umidadeDoAr, bus.umidadeDoSolo,
              bus.low, bus.middle, bus.high};
   endfunction

   task automatic set_raw(input logic [6:0] r);
      {bus.seletor_btn_n, bus.temperatura_raw, bus.umidadeDoAr_raw,
       bus.umidadeDoSolo_raw, bus.low_raw, bus.middle_raw,
       bus.high_raw} = r;
   endtask

   task automatic chk(input string name, input logic [8:0] exp);
      logic [8:0] got;
      got = outs();
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step(input string name, input logic [6:0] r,
                       input logic [8:0] exp);
      set_raw(r);
      @(negedge clk);
      chk(name, exp);
   endtask

   initial begin
      logic [8:0] e;
      n_vec = 0;
      n_err = 0;

      // reset idle, low step, high bounce
      tbl[0] = '{5, 7'b1000000, 9'h000};
      tbl[1] = '{1, 7'b1000000, 9'h100};
      tbl[2] = '{5, 7'b1000100, 9'h100};
      tbl[3] = '{2, 7'b1000100, 9'h104};
      tbl[4] = '{2, 7'b1000101, 9'h104};
      tbl[5] = '{2, 7'b1000100, 9'h104};
      tbl[6] = '{2, 7'b1000101, 9'h104};
      tbl[7] = '{2, 7'b1000100, 9'h104};
      tbl[8] = '{5, 7'b1000101, 9'h104};
      tbl[9] = '{2, 7'b1000101, 9'h105};

      reset = 1'b1;
      set_raw(7'b1000000);
      repeat (2) @(negedge clk);
      chk("reset_state", 9'h000);
      reset = 1'b0;

      for (int s = 0; s < 10; s++) begin
         for (int k = 0; k < tbl[s].n; k++) begin
            step($sformatf("tbl%0d_%0d", s, k), tbl[s].raw, tbl[s].exp);
         end
      end

      // first press: pulse and toggle on 7th edge
      for (int c = 1; c <= 20; c++) begin
         e = 9'h105;
         if (c == 7) e = e | 9'h080;
         if (c >= 7) e = e | 9'h040;
         step($sformatf("press1_%0d", c), 7'b0000101, e);
      end
      for (int c = 1; c <= 10; c++) begin
         step($sformatf("rel1_%0d", c), 7'b1000101, 9'h145);
      end
      // second press: back to page 0
      for (int c = 1; c <= 10; c++) begin
         e = (c < 7) ? 9'h145 : 9'h105;
         if (c == 7) e = e | 9'h080;
         step($sformatf("press2_%0d", c), 7'b0000101, e);
      end
      for (int c = 1; c <= 8; c++) begin
         step($sformatf("rel2_%0d", c), 7'b1000101, 9'h105);
      end

      // simultaneous solo/ar/temp step
      for (int c = 1; c <= 7; c++) begin
         e = (c < 6) ? 9'h105 : 9'h13D;
         step($sformatf("simul_%0d", c), 7'b1111101, e);
      end

      // middle counting reaches 2, then reset
      for (int c = 1; c <= 4; c++) begin
         step($sformatf("mid_cnt_%0d", c), 7'b1111111, 9'h13D);
      end
      reset = 1'b1;
      #1;
      chk("mid_reset", 9'h000);
      repeat (2) @(negedge clk);
      chk("mid_reset_hold", 9'h000);
      reset = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         e = (c < 6) ? 9'h000 : 9'h13F;
         step($sformatf("post_rst_%0d", c), 7'b1111111, e);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sensor_input_conditioner.md
Name: sensor_input_conditioner

Overview:
- Front-end stage feeding the irrigation controller top level.
- Synchronises and debounces the raw tank-level switches (high/middle/low) and the three field sensors (soil humidity, air humidity, temperature).
- Converts the active-low display-select pushbutton into a latched page-select level, producing the clean `seletor` input for the display mux.
- Also produces a `ready` flag that holds off the downstream alarm and valve logic until all inputs have been sampled stably after reset.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive clock cycles a synchronised input must differ from its filtered value before the filtered value updates (10 ms at 50 MHz). Legal range 1..2^CNT_W-1.
- CNT_W, 19: width of each debounce counter and of the startup counter.

Ports:
- clk  input  1  system clock, all flops rising-edge.
- reset  input  1  asynchronous, active-high reset.
- high_raw  input  1  raw upper tank level switch.
- middle_raw  input  1  raw middle tank level switch.
- low_raw  input  1  raw lower tank level switch.
- umidadeDoSolo_raw  input  1  raw soil humidity sensor.
- umidadeDoAr_raw  input  1  raw air humidity sensor.
- temperatura_raw  input  1  raw temperature sensor.
- seletor_btn_n  input  1  raw display-select pushbutton, active-low (0 = pressed).
- high  output  1  filtered high_raw.
- middle  output  1  filtered middle_raw.
- low  output  1  filtered low_raw.
- umidadeDoSolo  output  1  filtered soil humidity.
- umidadeDoAr  output  1  filtered air humidity.
- temperatura  output  1  filtered temperature.
- seletor  output  1  page select level: 0 = tank level page, 1 = irrigation page.
- seletor_pulse  output  1  one-cycle strobe on each accepted button press.
- ready  output  1  1 once the startup window after reset has elapsed.

Behaviour:
- Reset, asynchronous, active-high:
  - All synchroniser flops, filtered outputs, counters, seletor, seletor_pulse and ready are cleared to 0.
  - The button channel's synchroniser and filter reset to 1 (released).
  - Asserting reset mid-debounce or mid-press discards the in-progress state immediately.
- Channels: 7 identical channels (6 sensors plus the button). Each channel has:
  - a 2-flop synchroniser;
  - a filtered value;
  - a CNT_W-bit counter.
- Per-channel rules, evaluated every clock:
  - sync == filtered: counter <= 0.
  - sync != filtered and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync != filtered and counter == DEBOUNCE_CYCLES-1: filtered <= sync, counter <= 0.
- Latency: a clean step on a raw input appears on its filtered output exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples the new level.
- Glitch rejection:
  - Any bounce that returns sync to the filtered value before the count completes restarts the count from 0.
  - Pulses shorter than DEBOUNCE_CYCLES cycles never propagate.
- Counter width: counters saturate logically at DEBOUNCE_CYCLES-1 and never wrap.
- Channel independence: all channels are independent; simultaneous changes on several inputs each complete on their own schedule.
- Button press acceptance: the button filtered value's 1->0 transition is a press. In the cycle after that transition:
  - seletor_pulse = 1 for exactly one cycle;
  - seletor toggles.
- Button release: releases (0->1) produce no pulse. Holding the button produces exactly one toggle.
- Startup:
  - The startup counter increments from 0 after reset deasserts.
  - When it reaches DEBOUNCE_CYCLES+2, ready <= 1 and the counter stops.
  - ready stays 1 until the next reset.
  - Filtered outputs are valid but may still be 0 before ready.
- Outputs: all outputs are registered; there is no combinational path from any raw input to any output.

Test Plan:
1. DEBOUNCE_CYCLES=4, reset, then hold all raw inputs at 0 and button at 1 -> all outputs 0; ready rises on the 6th edge after reset release.
2. Clean step low_raw 0->1 -> low rises exactly 6 edges after the first sampling edge and stays 1.
3. Bounce: high_raw toggled 1,0,1,0 with 2-cycle dwell, then held 1 -> high stays 0 during the bounce; high=1 only 6 edges after the final settle.
4. Button press: seletor_btn_n held 0 for 20 cycles, then released -> single seletor_pulse; seletor 0->1; no pulse on release. A second press -> seletor 1->0.
5. Simultaneous step on umidadeDoSolo_raw, umidadeDoAr_raw and temperatura_raw -> all three filtered outputs change in the same cycle.
6. Reset asserted during counting (counter=2 on middle channel) -> middle stays 0; after reset release a fresh 6-edge latency applies; ready restarts from 0.
